// File: rtl/video_sync_gen_if.sv
// Video timing bundle between the sync generator and its pixel-side consumers.
// The generator owns every timing output; the consumer supplies the pixel enable.
interface video_sync_gen_if #(
    parameter int HCW = 10,
    parameter int VCW = 10
);
    logic           en;
    logic           hsync;
    logic           vsync;
    logic           de;
    logic           line_start;
    logic           frame_start;
    logic [HCW-1:0] hcount;
    logic [VCW-1:0] vcount;

    modport master (
        input  en,
        output hsync, vsync, de, line_start, frame_start, hcount, vcount
    );

    modport slave (
        output en,
        input  hsync, vsync, de, line_start, frame_start, hcount, vcount
    );
endinterface

// File: rtl/video_sync_gen.sv
// Raster timing generator: hsync/vsync/de, active coordinates and line/frame start pulses.
// Optional macro SYNC_ACTIVE_LOW_EN makes hsync/vsync active-low (idle/reset level 1).
module video_sync_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int HCW      = 10,
    parameter int VCW      = 10
) (
    input logic             clk,
    input logic             rst,
    video_sync_gen_if.master vs
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HPW     = $clog2(H_TOTAL);
    localparam int VPW     = $clog2(V_TOTAL);

    localparam logic [HPW-1:0] H_END_SYNC = HPW'(H_SYNC - 1);
    localparam logic [HPW-1:0] H_END_BP   = HPW'(H_SYNC + H_BP - 1);
    localparam logic [HPW-1:0] H_END_ACT  = HPW'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [HPW-1:0] H_END      = HPW'(H_TOTAL - 1);
    localparam logic [HPW-1:0] H_OFF      = HPW'(H_SYNC + H_BP);
    localparam logic [VPW-1:0] V_END_SYNC = VPW'(V_SYNC - 1);
    localparam logic [VPW-1:0] V_END_BP   = VPW'(V_SYNC + V_BP - 1);
    localparam logic [VPW-1:0] V_END_ACT  = VPW'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [VPW-1:0] V_END      = VPW'(V_TOTAL - 1);
    localparam logic [VPW-1:0] V_OFF      = VPW'(V_SYNC + V_BP);

`ifdef SYNC_ACTIVE_LOW_EN
    localparam logic SYNC_ON = 1'b0;
`else
    localparam logic SYNC_ON = 1'b1;
`endif

    typedef enum logic [1:0] {H_S_SYNC, H_S_BP, H_S_ACT, H_S_FP} h_state_t;
    typedef enum logic [1:0] {V_S_SYNC, V_S_BP, V_S_ACT, V_S_FP} v_state_t;

    h_state_t       h_state, h_nxt;
    v_state_t       v_state, v_nxt;
    logic [HPW-1:0] hpos, hpos_nxt;
    logic [VPW-1:0] vpos, vpos_nxt;
    logic           h_wrap;

    logic           hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
    logic [HCW-1:0] hcount_q;
    logic [VCW-1:0] vcount_q;
    logic           hsync_nxt, vsync_nxt, de_nxt, line_start_nxt, frame_start_nxt;
    logic [HCW-1:0] hcount_nxt;
    logic [VCW-1:0] vcount_nxt;

    // Reset parks the raster on the last position so the first enabled edge enters (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_state       <= H_S_FP;
            v_state       <= V_S_FP;
            hpos          <= H_END;
            vpos          <= V_END;
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
        end else begin
            h_state       <= h_nxt;
            v_state       <= v_nxt;
            hpos          <= hpos_nxt;
            vpos          <= vpos_nxt;
            hsync_q       <= hsync_nxt;
            vsync_q       <= vsync_nxt;
            de_q          <= de_nxt;
            line_start_q  <= line_start_nxt;
            frame_start_q <= frame_start_nxt;
            hcount_q      <= hcount_nxt;
            vcount_q      <= vcount_nxt;
        end
    end

    always_comb begin
        h_nxt    = h_state;
        v_nxt    = v_state;
        hpos_nxt = hpos;
        vpos_nxt = vpos;
        h_wrap   = 1'b0;
        if (vs.en) begin
            h_wrap   = (hpos == H_END);
            hpos_nxt = h_wrap ? '0 : hpos + 1'b1;
            unique case (h_state)
                H_S_SYNC: if (hpos == H_END_SYNC) h_nxt = H_S_BP;
                H_S_BP:   if (hpos == H_END_BP)   h_nxt = H_S_ACT;
                H_S_ACT:  if (hpos == H_END_ACT)  h_nxt = H_S_FP;
                default:  if (h_wrap)             h_nxt = H_S_SYNC;
            endcase
            // The vertical side only moves on the line wrap.
            if (h_wrap) begin
                vpos_nxt = (vpos == V_END) ? '0 : vpos + 1'b1;
                unique case (v_state)
                    V_S_SYNC: if (vpos == V_END_SYNC) v_nxt = V_S_BP;
                    V_S_BP:   if (vpos == V_END_BP)   v_nxt = V_S_ACT;
                    V_S_ACT:  if (vpos == V_END_ACT)  v_nxt = V_S_FP;
                    default:  if (vpos == V_END)      v_nxt = V_S_SYNC;
                endcase
            end
        end
    end

    // Decode from the next position so registered outputs line up with the position itself.
    always_comb begin
        hsync_nxt       = (h_nxt == H_S_SYNC) ? SYNC_ON : ~SYNC_ON;
        vsync_nxt       = (v_nxt == V_S_SYNC) ? SYNC_ON : ~SYNC_ON;
        de_nxt          = (h_nxt == H_S_ACT) && (v_nxt == V_S_ACT);
        hcount_nxt      = de_nxt ? HCW'(hpos_nxt - H_OFF) : '0;
        vcount_nxt      = (v_nxt == V_S_ACT) ? VCW'(vpos_nxt - V_OFF) : '0;
        line_start_nxt  = h_wrap;
        frame_start_nxt = h_wrap && (vpos_nxt == '0);
    end

    assign vs.hsync       = hsync_q;
    assign vs.vsync       = vsync_q;
    assign vs.de          = de_q;
    assign vs.line_start  = line_start_q;
    assign vs.frame_start = frame_start_q;
    assign vs.hcount      = hcount_q;
    assign vs.vcount      = vcount_q;
endmodule

// File: tb/tb_video_sync_gen.sv
// Directed bench for video_sync_gen on a tiny 15x8 raster (H 3/2/8/2, V 2/1/4/1).
// Sync polarity expectations follow SYNC_ACTIVE_LOW_EN the same way the design does.
module tb_video_sync_gen;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

`ifdef SYNC_ACTIVE_LOW_EN
    localparam logic SON = 1'b0;
`else
    localparam logic SON = 1'b1;
`endif

    video_sync_gen_if #(.HCW(3), .VCW(2)) vif ();

    video_sync_gen #(
        .H_SYNC(3), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
        .HCW(3), .VCW(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vs  (vif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic e);
        vif.en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst    = 1'b1;
        vif.en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        vif.en = 1'b1;
        repeat (3) applyStimulus(1'b1);
        n_cmp++; if (vif.hsync !== ~SON)      begin n_fail++; $display("[TB] FAIL reset_hsync got %b want %b", vif.hsync, ~SON); end
        n_cmp++; if (vif.vsync !== ~SON)      begin n_fail++; $display("[TB] FAIL reset_vsync got %b want %b", vif.vsync, ~SON); end
        n_cmp++; if (vif.de !== 1'b0)         begin n_fail++; $display("[TB] FAIL reset_de got %b want 0", vif.de); end
        n_cmp++; if (vif.line_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_line_start got %b want 0", vif.line_start); end
        n_cmp++; if (vif.frame_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_start got %b want 0", vif.frame_start); end
        n_cmp++; if (vif.hcount !== 3'd0)     begin n_fail++; $display("[TB] FAIL reset_hcount got %0d want 0", vif.hcount); end
        n_cmp++; if (vif.vcount !== 2'd0)     begin n_fail++; $display("[TB] FAIL reset_vcount got %0d want 0", vif.vcount); end
        rst = 1'b0;
    endtask

    // Two full frames with en held high; position k maps to hpos k%15, vpos (k/15)%8.
    task automatic test_frames();
        int   vs_high = 0;
        int   fs_cnt  = 0;
        int   ls_cnt  = 0;
        logic e_hs, e_vs, e_de, e_ls, e_fs;
        logic [2:0] e_hc;
        logic [1:0] e_vc;
        for (int k = 0; k < 240; k++) begin
            int hp = k % 15;
            int vp = (k / 15) % 8;
            applyStimulus(1'b1);
            e_hs = (hp < 3) ? SON : ~SON;
            e_vs = (vp < 2) ? SON : ~SON;
            e_de = (hp >= 5 && hp <= 12) && (vp >= 3 && vp <= 6);
            e_hc = e_de ? 3'(hp - 5) : 3'd0;
            e_vc = (vp >= 3 && vp <= 6) ? 2'(vp - 3) : 2'd0;
            e_ls = (hp == 0);
            e_fs = (hp == 0) && (vp == 0);
            if (vif.vsync === SON) vs_high++;
            if (vif.frame_start === 1'b1) fs_cnt++;
            if (vif.line_start === 1'b1) ls_cnt++;
            n_cmp++; if (vif.hsync !== e_hs)       begin n_fail++; $display("[TB] FAIL frames_hsync k=%0d got %b want %b", k, vif.hsync, e_hs); end
            n_cmp++; if (vif.vsync !== e_vs)       begin n_fail++; $display("[TB] FAIL frames_vsync k=%0d got %b want %b", k, vif.vsync, e_vs); end
            n_cmp++; if (vif.de !== e_de)          begin n_fail++; $display("[TB] FAIL frames_de k=%0d got %b want %b", k, vif.de, e_de); end
            n_cmp++; if (vif.hcount !== e_hc)      begin n_fail++; $display("[TB] FAIL frames_hcount k=%0d got %0d want %0d", k, vif.hcount, e_hc); end
            n_cmp++; if (vif.vcount !== e_vc)      begin n_fail++; $display("[TB] FAIL frames_vcount k=%0d got %0d want %0d", k, vif.vcount, e_vc); end
            n_cmp++; if (vif.line_start !== e_ls)  begin n_fail++; $display("[TB] FAIL frames_line_start k=%0d got %b want %b", k, vif.line_start, e_ls); end
            n_cmp++; if (vif.frame_start !== e_fs) begin n_fail++; $display("[TB] FAIL frames_frame_start k=%0d got %b want %b", k, vif.frame_start, e_fs); end
        end
        n_cmp++; if (vs_high != 60) begin n_fail++; $display("[TB] FAIL frames_vsync_clks got %0d want 60", vs_high); end
        n_cmp++; if (fs_cnt != 2)   begin n_fail++; $display("[TB] FAIL frames_frame_start_cnt got %0d want 2", fs_cnt); end
        n_cmp++; if (ls_cnt != 16)  begin n_fail++; $display("[TB] FAIL frames_line_start_cnt got %0d want 16", ls_cnt); end
    endtask

    // en toggles 1,0: outputs hold on the idle edge and the start pulses last one clk.
    task automatic test_en_alternate();
        int   hs_high = 0;
        logic e_hs, e_de;
        logic [2:0] e_hc;
        doReset();
        for (int i = 0; i < 60; i++) begin
            int hp = i % 15;
            int vp = (i / 15) % 8;
            e_hs = (hp < 3) ? SON : ~SON;
            e_de = (hp >= 5 && hp <= 12) && (vp >= 3 && vp <= 6);
            e_hc = e_de ? 3'(hp - 5) : 3'd0;
            for (int ph = 0; ph < 2; ph++) begin
                applyStimulus(ph == 0);
                if (i < 15 && vif.hsync === SON) hs_high++;
                n_cmp++; if (vif.hsync !== e_hs) begin n_fail++; $display("[TB] FAIL alt_hsync i=%0d ph=%0d got %b want %b", i, ph, vif.hsync, e_hs); end
                n_cmp++; if (vif.de !== e_de)    begin n_fail++; $display("[TB] FAIL alt_de i=%0d ph=%0d got %b want %b", i, ph, vif.de, e_de); end
                n_cmp++; if (vif.hcount !== e_hc) begin n_fail++; $display("[TB] FAIL alt_hcount i=%0d ph=%0d got %0d want %0d", i, ph, vif.hcount, e_hc); end
                n_cmp++; if (vif.line_start !== (ph == 0 && hp == 0)) begin n_fail++; $display("[TB] FAIL alt_line_start i=%0d ph=%0d got %b", i, ph, vif.line_start); end
                n_cmp++; if (vif.frame_start !== (ph == 0 && hp == 0 && vp == 0)) begin n_fail++; $display("[TB] FAIL alt_frame_start i=%0d ph=%0d got %b", i, ph, vif.frame_start); end
            end
        end
        n_cmp++; if (hs_high != 6) begin n_fail++; $display("[TB] FAIL alt_hsync_clks got %0d want 6", hs_high); end
    endtask

    // Reset lands inside the active area at vpos 4, hpos 9 (position index 69).
    task automatic test_reset_mid();
        doReset();
        repeat (70) applyStimulus(1'b1);
        n_cmp++; if (vif.de !== 1'b1)     begin n_fail++; $display("[TB] FAIL mid_pre_de got %b want 1", vif.de); end
        n_cmp++; if (vif.hcount !== 3'd4) begin n_fail++; $display("[TB] FAIL mid_pre_hcount got %0d want 4", vif.hcount); end
        n_cmp++; if (vif.vcount !== 2'd1) begin n_fail++; $display("[TB] FAIL mid_pre_vcount got %0d want 1", vif.vcount); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (vif.de !== 1'b0)      begin n_fail++; $display("[TB] FAIL mid_rst_de got %b want 0", vif.de); end
        n_cmp++; if (vif.hcount !== 3'd0)  begin n_fail++; $display("[TB] FAIL mid_rst_hcount got %0d want 0", vif.hcount); end
        n_cmp++; if (vif.vcount !== 2'd0)  begin n_fail++; $display("[TB] FAIL mid_rst_vcount got %0d want 0", vif.vcount); end
        n_cmp++; if (vif.hsync !== ~SON)   begin n_fail++; $display("[TB] FAIL mid_rst_hsync got %b want %b", vif.hsync, ~SON); end
        n_cmp++; if (vif.vsync !== ~SON)   begin n_fail++; $display("[TB] FAIL mid_rst_vsync got %b want %b", vif.vsync, ~SON); end
        applyStimulus(1'b1);
        n_cmp++; if (vif.line_start !== 1'b0)  begin n_fail++; $display("[TB] FAIL mid_hold_line_start got %b want 0", vif.line_start); end
        n_cmp++; if (vif.frame_start !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_hold_frame_start got %b want 0", vif.frame_start); end
        rst = 1'b0;
        applyStimulus(1'b1);
        n_cmp++; if (vif.frame_start !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_after_frame_start got %b want 1", vif.frame_start); end
        n_cmp++; if (vif.line_start !== 1'b1)  begin n_fail++; $display("[TB] FAIL mid_after_line_start got %b want 1", vif.line_start); end
        n_cmp++; if (vif.hsync !== SON)        begin n_fail++; $display("[TB] FAIL mid_after_hsync got %b want %b", vif.hsync, SON); end
        n_cmp++; if (vif.vsync !== SON)        begin n_fail++; $display("[TB] FAIL mid_after_vsync got %b want %b", vif.vsync, SON); end
        n_cmp++; if (vif.de !== 1'b0)          begin n_fail++; $display("[TB] FAIL mid_after_de got %b want 0", vif.de); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        vif.en = 1'b0;
        $display("[TB] start");
        test_reset();
        test_frames();
        test_en_alternate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
